// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU execute path: sizes, ALU opcodes,
// sequencer state encoding and opcode classification.
package cpu_pkg;

  localparam int CPU_WIDTH = 16;
  localparam int CPU_AW    = 3;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RDA  = 3'd1,
    S_RDB  = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_e;

  // Unary ops (NOT, SHL, MOV) occupy the top of the opcode space and skip the B read.
  function automatic logic is_unary(input logic [2:0] op);
    return op >= OP_NOT;
  endfunction

endpackage

// File: rtl/alu16.sv
// Combinational ALU for the execute sequencer. The carry output and its
// extra result bit exist only when ALU_FLAGS_EN is defined.
module alu16
  import cpu_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result
`ifdef ALU_FLAGS_EN
  ,
  output logic             carry
`endif
);

`ifdef ALU_FLAGS_EN
  localparam int RW = WIDTH + 1;
`else
  localparam int RW = WIDTH;
`endif

  // The bit above the result is carry/borrow for ADD/SUB and the shifted-out bit for SHL.
  logic [RW-1:0] wide;

  always_comb begin
    wide = '0;
    case (op)
      OP_ADD:  wide = RW'(a) + RW'(b);
      OP_SUB:  wide = RW'(a) - RW'(b);
      OP_AND:  wide = RW'(a & b);
      OP_OR:   wide = RW'(a | b);
      OP_XOR:  wide = RW'(a ^ b);
      OP_NOT:  wide = RW'(~a);
      OP_SHL:  wide = RW'({a, 1'b0});
      OP_MOV:  wide = RW'(a);
      default: wide = '0;
    endcase
  end

  assign result = wide[WIDTH-1:0];
`ifdef ALU_FLAGS_EN
  assign carry = wide[RW-1];
`endif

endmodule

// File: rtl/alu_sequencer.sv
// Multicycle execute sequencer: reads operands through the shared register bank
// read port, runs alu16 and writes the result back. ALU_FLAGS_EN adds the {N,Z,C} flags port.
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH,
  parameter int AW    = CPU_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    rd_addr,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    rf_pa,
  output logic             rf_rd,
  input  logic [WIDTH-1:0] rf_p,
  output logic [AW-1:0]    rf_wpa,
  output logic             rf_wr,
  output logic [WIDTH-1:0] rf_din
`ifdef ALU_FLAGS_EN
  ,
  output logic [2:0]       flags
`endif
);

  state_e           state_q, state_d;
  logic [2:0]       op_q;
  logic [AW-1:0]    rd_q, rs1_q, rs2_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] din_q;
  logic [AW-1:0]    wpa_q;
  logic             wr_q, done_q;
  logic [WIDTH-1:0] alu_res;

`ifdef ALU_FLAGS_EN
  logic             alu_c;
  logic [2:0]       flags_q;
`endif

  alu16 #(.WIDTH(WIDTH)) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_res)
`ifdef ALU_FLAGS_EN
    ,
    .carry  (alu_c)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RDA;
      S_RDA:   state_d = is_unary(op_q) ? S_EXEC : S_RDB;
      S_RDB:   state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The read port is driven only during the two operand-fetch states.
  always_comb begin
    busy  = (state_q != S_IDLE);
    rf_rd = (state_q == S_RDA) || (state_q == S_RDB);
    rf_pa = '0;
    if (state_q == S_RDA)      rf_pa = rs1_q;
    else if (state_q == S_RDB) rf_pa = rs2_q;
  end

  // Operand capture, then the EXEC stage registers result/address/strobe for WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= '0;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      din_q  <= '0;
      wpa_q  <= '0;
      wr_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) begin
        op_q  <= op;
        rd_q  <= rd_addr;
        rs1_q <= rs1;
        rs2_q <= rs2;
      end
      if (state_q == S_RDA) a_q <= rf_p;
      if (state_q == S_RDB) b_q <= rf_p;
      if (state_q == S_EXEC) begin
        din_q <= alu_res;
        wpa_q <= rd_q;
      end
      wr_q   <= (state_q == S_EXEC);
      done_q <= (state_q == S_EXEC);
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst)                    flags_q <= '0;
    else if (state_q == S_EXEC) flags_q <= {alu_res[WIDTH-1], (alu_res == '0), alu_c};
  end

  assign flags = flags_q;
`endif

  assign rf_din = din_q;
  assign rf_wpa = wpa_q;
  assign rf_wr  = wr_q;
  assign done   = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: register bank model, directed cases
// and randomized instructions against an arithmetic reference model.
module tb_alu_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [2:0]  rd_addr, rs1, rs2;
  logic        busy, done;
  logic [2:0]  rf_pa;
  logic        rf_rd;
  logic [15:0] rf_p;
  logic [2:0]  rf_wpa;
  logic        rf_wr;
  logic [15:0] rf_din;
`ifdef ALU_FLAGS_EN
  logic [2:0]  flags;
`endif

  logic [15:0] bank [8];
  int          mdl  [8];
  logic        load_en;
  logic [2:0]  load_addr;
  logic [15:0] load_data;

  int checks = 0;
  int errors = 0;

  alu_sequencer dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rd_addr (rd_addr),
    .rs1     (rs1),
    .rs2     (rs2),
    .busy    (busy),
    .done    (done),
    .rf_pa   (rf_pa),
    .rf_rd   (rf_rd),
    .rf_p    (rf_p),
    .rf_wpa  (rf_wpa),
    .rf_wr   (rf_wr),
    .rf_din  (rf_din)
`ifdef ALU_FLAGS_EN
    ,
    .flags   (flags)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register bank: shared read bus is junk unless the sequencer enables the read.
  assign rf_p = rf_rd ? bank[rf_pa] : 16'hBAD0;

  always @(posedge clk) begin
    if (load_en)    bank[load_addr] <= load_data;
    else if (rf_wr) bank[rf_wpa]    <= rf_din;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference ALU: returns {N,Z,C,result[15:0]} computed with plain integer arithmetic.
  function automatic logic [18:0] ref_exec(input int opc, input int a, input int b);
    int r;
    bit c;
    c = 1'b0;
    case (opc)
      0: begin r = a + b; c = (r >= 65536); end
      1: begin r = a - b; c = (a < b); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = 65535 - a;
      6: begin r = a * 2; c = (a >= 32768); end
      default: r = a;
    endcase
    r = r & 32'hFFFF;
    return {(r >= 32768), (r == 0), c, 16'(r)};
  endfunction

  task automatic load(input int a, input int v);
    load_en   = 1'b1;
    load_addr = 3'(a);
    load_data = 16'(v);
    mdl[a]    = v & 32'hFFFF;
    @(negedge clk);
    load_en   = 1'b0;
  endtask

  // Issues one instruction from an IDLE cycle and checks every cycle through the one after WB.
  task automatic run_instr(input int opc, input int d, input int s1, input int s2, input bit poke);
    logic [18:0] ev;
    bit un;
    un = (opc >= 5);
    ev = ref_exec(opc, mdl[s1], un ? 0 : mdl[s2]);
    mdl[d] = int'(ev[15:0]);
    start = 1'b1; op = 3'(opc); rd_addr = 3'(d); rs1 = 3'(s1); rs2 = 3'(s2);
    @(negedge clk);
    start = 1'b0;
    chk("rda_pa", 32'(rf_pa), 32'(s1));
    chk("rda_rd", 32'(rf_rd), 1);
    chk("rda_busy", 32'(busy), 1);
    chk("rda_wr", 32'(rf_wr), 0);
    if (!un) begin
      if (poke) begin
        start = 1'b1; op = 3'd7; rd_addr = 3'(d + 1); rs1 = 3'(s2 + 1); rs2 = 3'(s1 + 1);
      end
      @(negedge clk);
      start = 1'b0;
      chk("rdb_pa", 32'(rf_pa), 32'(s2));
      chk("rdb_rd", 32'(rf_rd), 1);
    end
    @(negedge clk);
    chk("ex_rd", 32'(rf_rd), 0);
    chk("ex_wr", 32'(rf_wr), 0);
    chk("ex_busy", 32'(busy), 1);
    @(negedge clk);
    chk("wb_wr", 32'(rf_wr), 1);
    chk("wb_done", 32'(done), 1);
    chk("wb_busy", 32'(busy), 1);
    chk("wb_rd", 32'(rf_rd), 0);
    chk("wb_wpa", 32'(rf_wpa), 32'(d));
    chk("wb_din", 32'(rf_din), 32'(ev[15:0]));
`ifdef ALU_FLAGS_EN
    chk("wb_flags", 32'(flags), 32'(ev[18:16]));
`endif
    @(negedge clk);
    chk("post_busy", 32'(busy), 0);
    chk("post_wr", 32'(rf_wr), 0);
    chk("post_done", 32'(done), 0);
    chk("post_din", 32'(rf_din), 32'(ev[15:0]));
    chk("post_wpa", 32'(rf_wpa), 32'(d));
  endtask

  task automatic abort_in_rdb(input int d, input int s1, input int s2);
    start = 1'b1; op = 3'd0; rd_addr = 3'(d); rs1 = 3'(s1); rs2 = 3'(s2);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("ab_in_rdb", 32'(rf_pa), 32'(s2));
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    chk("ab_busy", 32'(busy), 0);
    chk("ab_rd", 32'(rf_rd), 0);
    chk("ab_wr", 32'(rf_wr), 0);
    chk("ab_pa", 32'(rf_pa), 0);
    chk("ab_din", 32'(rf_din), 0);
    rst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("ab_nowr", 32'(rf_wr), 0);
      chk("ab_idle", 32'(busy), 0);
    end
    chk("ab_bank", 32'(bank[d]), 32'(mdl[d]));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; rd_addr = '0; rs1 = '0; rs2 = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    for (int i = 0; i < 8; i++) mdl[i] = 0;

    // Reset held two cycles
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rd", 32'(rf_rd), 0);
    chk("rst_wr", 32'(rf_wr), 0);
    chk("rst_pa", 32'(rf_pa), 0);
    chk("rst_wpa", 32'(rf_wpa), 0);
    chk("rst_din", 32'(rf_din), 0);
`ifdef ALU_FLAGS_EN
    chk("rst_flags", 32'(flags), 0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 8; i++) load(i, 0);
    for (int i = 0; i < 3; i++) begin
      chk("idle_rd", 32'(rf_rd), 0);
      chk("idle_busy", 32'(busy), 0);
      @(negedge clk);
    end

    // Directed cases
    load(1, 16'h1234); load(2, 16'h0FFF);
    run_instr(0, 3, 1, 2, 1'b0);
    chk("add_r3", 32'(bank[3]), 32'h2233);

    load(4, 16'h0001); load(5, 16'h0002);
    run_instr(1, 6, 4, 5, 1'b0);
    chk("sub_r6", 32'(bank[6]), 32'hFFFF);

    load(0, 16'h00F0);
    run_instr(5, 1, 0, 5, 1'b0);
    chk("not_r1", 32'(bank[1]), 32'hFF0F);

    load(7, 16'h8000);
    run_instr(0, 7, 7, 7, 1'b0);
    chk("add77_r7", 32'(bank[7]), 32'h0000);
    run_instr(7, 2, 7, 0, 1'b0);
    chk("mov_r2", 32'(bank[2]), 32'h0000);

    load(4, 16'h4321); load(5, 16'h1111);
    run_instr(4, 0, 4, 5, 1'b1);
    chk("poke_r0", 32'(bank[0]), 32'h5230);

    abort_in_rdb(3, 4, 5);

    // Randomized instructions, occasionally loading corner values
    for (int i = 0; i < 8; i++) load(i, int'($urandom_range(0, 65535)));
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        case ($urandom_range(0, 3))
          0: load(int'($urandom_range(0, 7)), 16'hFFFF);
          1: load(int'($urandom_range(0, 7)), 16'h8000);
          2: load(int'($urandom_range(0, 7)), 16'h0000);
          default: load(int'($urandom_range(0, 7)), 16'h0001);
        endcase
      end
      run_instr(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0));
    end

    for (int i = 0; i < 8; i++) chk("final_bank", 32'(bank[i]), 32'(mdl[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multicycle execute sequencer for the 16-bit CPU datapath. It sits directly downstream of the 8×16 register bank's single shared read port and upstream of its write port. It accepts one decoded register-register instruction and fetches its operands through that one read port, one per cycle. It then computes the ALU result and writes it back with a one-cycle write strobe.

## Interface
Parameters:
- WIDTH, 16, datapath / register width
- AW, 3, register address width (8 registers)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  instruction valid; sampled only in IDLE
- op  in  3  ALU opcode
- rd_addr  in  AW  destination register
- rs1  in  AW  source A register
- rs2  in  AW  source B register
- busy  out  1  high from first read cycle through writeback cycle
- done  out  1  one-cycle pulse in the writeback cycle
- rf_pa  out  AW  register bank read address
- rf_rd  out  1  register bank read enable; drives the shared read bus only when high
- rf_p  in  WIDTH  register bank read data
- rf_wpa  out  AW  register bank write address
- rf_wr  out  1  register bank write strobe
- rf_din  out  WIDTH  register bank write data
- flags  out  3  {N, Z, C}; present only with ALU_FLAGS_EN

## Operation
- Opcodes:
  - 000 ADD A+B
  - 001 SUB A−B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 NOT A
  - 110 SHL A by 1 (zero fill)
  - 111 MOV A
- Binary ops are 000–100. Unary ops are 101–111; unary ops never read rs2.
- FSM states: IDLE, RDA, RDB, EXEC, WB.
- IDLE:
  - On start=1, latch op/rd_addr/rs1/rs2 and go to RDA.
  - start is ignored in every other state; there is no queueing.
- RDA: rf_pa=rs1, rf_rd=1. Capture rf_p into A at the edge. Next state is RDB if binary, otherwise EXEC.
- RDB: rf_pa=rs2, rf_rd=1. Capture rf_p into B. Next state is EXEC.
- EXEC: compute into the result register. rf_rd=0. Next state is WB.
- WB: rf_wr=1, rf_wpa=rd_addr, rf_din=result, done=1. Next state is IDLE.
- rf_rd is 0 in every state except RDA and RDB, so the shared bus is released.
- Arithmetic is modulo 2^WIDTH.
  - Carry C: ADD C = carry out of bit 15; SUB C = borrow (A<B unsigned); SHL C = A[15].
  - C is 0 for logic, NOT and MOV.
  - Z = result==0. N = result[15].
- rs1, rs2 and rd_addr may be equal. Operands are captured before writeback, so no hazard arises.

## Timing
- Start accepted at edge T.
  - Binary: RDA T+1, RDB T+2, EXEC T+3, WB T+4.
  - Unary: RDA T+1, EXEC T+2, WB T+3.
- Minimum start-to-start spacing: binary 5 cycles, unary 4 cycles. The next start can be accepted in the cycle after WB.
- rf_wr and done are high for exactly one cycle and are registered outputs.
- rf_wpa and rf_din are registered at the end of EXEC. They stay stable through WB and the following cycle, until the next EXEC.
- Reset values:
  - State IDLE; busy=0, done=0, rf_rd=0, rf_wr=0.
  - rf_pa=0, rf_wpa=0, rf_din=0, flags=0.
  - A, B, result and latched fields all 0.
- rst asserted in any state, including mid-instruction: IDLE after that edge. No rf_wr is issued for the aborted instruction. rst has priority over start.

## Configuration
- ALU_FLAGS_EN defined:
  - A 3-bit flags register {N,Z,C} loads at the end of EXEC, so it is visible from the WB cycle.
  - It holds its value until the next EXEC.
  - flags port present.
- Not defined: no flags register and no flags port. Carry/zero logic is not built. All other behaviour is identical.

## Structure
- Shared package cpu_pkg holds:
  - WIDTH/AW constants
  - opcode constants (OP_ADD..OP_MOV)
  - FSM state encoding
  - an is_unary helper
- One sub-module, alu16: purely combinational. Inputs are op, A, B; outputs are result and carry. It is instantiated once in EXEC.

## Test plan
- Reset: hold rst 2 cycles → all outputs 0, busy=0; rf_rd=0 every cycle after.
- ADD, bank model r1=0x1234, r2=0x0FFF, rd=3, start at T:
  - rf_pa=1 at T+1, rf_pa=2 at T+2.
  - At T+4: rf_wr=1, rf_wpa=3, rf_din=0x2233, done=1.
  - Flags {N,Z,C}=000.
- SUB, r4=0x0001, r5=0x0002, rd=6 → rf_din=0xFFFF at T+4; flags N=1, Z=0, C=1.
- NOT, r0=0x00F0, rd=1 → only one read cycle (rf_pa=0); rf_wr at T+3 with rf_din=0xFF0F; rf_rd never high at T+2.
- ADD with rs1=rs2=rd=7, r7=0x8000 → rf_din=0x0000, Z=1, C=1; subsequent read of r7 returns 0x0000.
- Abort and busy:
  - start pulsed during RDB is ignored; instruction completes normally.
  - rst asserted in RDB of a new instruction → IDLE next cycle; rf_wr never asserts; register contents unchanged.
